global_tick_gen: RTL and testbench
==================================

# global_tick_gen

Generates the per-subsystem clock ticks and the combined global tick that subsystem-level global clocking blocks and `$global_clock` consumers sample. It runs off one system clock and holds N_SUB independent programmable dividers. Each divider emits a one-cycle tick strobe per period, and `global_tick` is the OR of all strobes, matching an `@(clk1 or clk2)` style global event. Divider values are reprogrammed through a valid/ready handshake and take effect only on period boundaries, so no consumer sees a truncated period.

## Interface
Parameters:
- N_SUB, 2, number of subsystem tick channels (≥1)
- DIV_W, 8, divider width; legal divide values 0..2^DIV_W-1
- DIV_RST, 1, divide value of every channel after reset

Ports:
- clk  input  1  system clock; single clock domain
- rst_n  input  1  reset; asynchronous assert, active-low
- run  input  1  1 = counters advance; 0 = all counters hold
- sync  input  1  one-cycle pulse; realigns all channel phases
- cfg_valid  input  1  config request
- cfg_ready  output  1  config slot free
- cfg_sel  input  max(1,$clog2(N_SUB))  target channel
- cfg_div  input  DIV_W  new divide value; 0 = channel disabled
- tick  output  N_SUB  per-channel tick strobes, registered
- global_tick  output  1  OR of next-state tick bits, registered
- busy  output  1  update pending (== !cfg_ready)

## Operation
- Each channel i has `cnt[i]` (DIV_W bits) and `div[i]`. While run=1 and div[i]≠0:
  - If cnt[i]==div[i]-1: cnt[i]←0 and tick[i]←1.
  - Else: cnt[i]←cnt[i]+1 and tick[i]←0.
- div[i]=1 ticks every cycle. A channel with div[i]=0, or any channel while run=0, holds cnt and drives tick[i]=0.
- Config FSM states:
  - CFG_IDLE: cfg_ready=1. A transfer happens on a cycle with cfg_valid&cfg_ready. It latches pend_sel/pend_div and goes to CFG_PENDING.
  - CFG_PENDING: cfg_ready=0. The pending value is applied to div[pend_sel] on the first cycle in which any one of these holds:
    - the channel wraps (cnt==div-1 with run=1);
    - the channel is disabled (div=0);
    - run=0;
    - sync=1.
  - On apply, cnt[pend_sel]←0 and the FSM returns to CFG_IDLE.
- cfg_sel ≥ N_SUB: the transfer is accepted and dropped. The FSM stays in CFG_IDLE.
- sync=1: all cnt←0 and no tick that cycle. sync has priority over counting and wrap.
- Simultaneous wrap and apply on the same channel: the tick for the finishing period is still issued, and the new div governs the next period.
- Reset (at any time, including mid-update): cnt=0, div=DIV_RST, tick=0, global_tick=0, FSM=CFG_IDLE, cfg_ready=1, busy=0. The pending value is discarded.

## Timing
- All outputs are flops. No combinational path from any input to any output.
- With run held high from cycle 0 and cnt=0, tick[i] is high in cycles D, 2D, 3D… where D=div[i]. The period is exactly D cycles, with duty 1/D.
- global_tick is high in exactly the cycles where any tick bit is high.
- cfg_ready drops the cycle after acceptance. It rises the cycle after apply. Back-to-back configs therefore need at least 2 cycles between acceptances.
- Apply latency after acceptance is ≤ old div cycles. It is 1 cycle if the channel is disabled, run=0, or sync is asserted.
- After a run 0→1 transition, counting resumes from the held cnt. Phase is preserved across the pause.

## Structure
- Package `global_tick_pkg` holds:
  - `cfg_state_t` enum {CFG_IDLE, CFG_PENDING};
  - default DIV_W;
  - `div_t` typedef (logic [DIV_W-1:0]).
- Sub-module `tick_div_chan`, instantiated N_SUB times in a generate loop.
  - Inputs: run, sync, load, load_div.
  - Outputs: tick, wrap_next (cnt==div-1 && run && div≠0).
  - It owns cnt and div.
- The top level owns the config FSM, the pending registers and the global_tick OR.

## Test plan
- Reset, run=1, DIV_RST=1 → tick[0]=tick[1]=1 and global_tick=1 every cycle from cycle 1. Assert rst_n low mid-stream → all outputs 0 asynchronously.
- Config ch0 div=4, ch1 div=6, run=1 → tick[0] period 4, tick[1] period 6. global_tick is high at cycles 4,6,8,12,16,18,20,24 relative to alignment.
- ch0 at div=5 mid-period (cnt=2), write div=3 → busy for 2 cycles. The old period completes (tick) and the next ticks are 3 cycles apart. cfg_ready=0 throughout.
- Pulse sync while ch0=4, ch1=6 are out of phase → both cnt=0 and no tick that cycle. The next ticks land 4 and 6 cycles after sync.
- run=0 for 10 cycles at ch0 cnt=1, div=4 → no ticks while stopped. After run=1, the tick comes exactly 3 cycles later. A config issued during run=0 applies in 1 cycle.
- Write div=0 to ch1 → tick[1] stays 0. Write cfg_sel=3 with N_SUB=2 → accepted, no state change, cfg_ready stays 1.

Source files
------------

// File: rtl/global_tick_pkg.sv
// Shared types and defaults for the global tick generator.
package global_tick_pkg;

  localparam int DIV_W_DEFAULT = 8;

  typedef enum logic {
    CFG_IDLE,
    CFG_PENDING
  } cfg_state_t;

  typedef logic [DIV_W_DEFAULT-1:0] div_t;

endpackage

// File: rtl/tick_div_chan.sv
// One programmable divider channel: owns its counter and divide value and
// emits a one-cycle registered tick at the end of every period.
module tick_div_chan
  import global_tick_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEFAULT,
  parameter int DIV_RST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             sync,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             tick,
  output logic             tick_next,
  output logic             wrap_next,
  output logic             div_zero
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;

  assign div_zero  = (div_q == '0);
  assign wrap_next = run && !div_zero && (cnt_q == (div_q - DIV_W'(1)));
  assign tick      = tick_q;
  assign tick_next = tick_d;

  // Next-state: sync beats wrap beats count; a load restarts the period but
  // keeps the tick of a period that finishes in the same cycle.
  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    tick_d = 1'b0;
    if (sync) begin
      cnt_d = '0;
    end else if (wrap_next) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else if (run && !div_zero) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    if (load) begin
      div_d = load_div;
      cnt_d = '0;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      div_q  <= DIV_W'(DIV_RST);
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/global_tick_gen.sv
// Global tick generator: N_SUB divider channels, a one-deep config slot that
// applies new divide values only on period boundaries, and the OR'd global tick.
module global_tick_gen
  import global_tick_pkg::*;
#(
  parameter  int N_SUB   = 2,
  parameter  int DIV_W   = DIV_W_DEFAULT,
  parameter  int DIV_RST = 1,
  localparam int SEL_W   = (N_SUB > 1) ? $clog2(N_SUB) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             sync,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [DIV_W-1:0] cfg_div,
  output logic [N_SUB-1:0] tick,
  output logic             global_tick,
  output logic             busy
);

  cfg_state_t       state_q, state_d;
  logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             busy_q, busy_d;
  logic             global_tick_q, global_tick_d;

  logic [N_SUB-1:0] load;
  logic [N_SUB-1:0] tick_nxt;
  logic [N_SUB-1:0] wrap_next;
  logic [N_SUB-1:0] div_zero;

  assign cfg_ready   = cfg_ready_q;
  assign busy        = busy_q;
  assign global_tick = global_tick_q;

  for (genvar g = 0; g < N_SUB; g++) begin : g_chan
    tick_div_chan #(
      .DIV_W  (DIV_W),
      .DIV_RST(DIV_RST)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .sync     (sync),
      .load     (load[g]),
      .load_div (pend_div_q),
      .tick     (tick[g]),
      .tick_next(tick_nxt[g]),
      .wrap_next(wrap_next[g]),
      .div_zero (div_zero[g])
    );
  end

  // Config FSM next-state: accept into the slot, then release it to the target
  // channel at the first safe boundary (wrap, disabled, stopped or sync).
  always_comb begin
    state_d       = state_q;
    pend_sel_d    = pend_sel_q;
    pend_div_d    = pend_div_q;
    cfg_ready_d   = cfg_ready_q;
    busy_d        = busy_q;
    load          = '0;
    global_tick_d = |tick_nxt;
    case (state_q)
      CFG_IDLE: begin
        if (cfg_valid && cfg_ready_q && (int'(cfg_sel) < N_SUB)) begin
          pend_sel_d  = cfg_sel;
          pend_div_d  = cfg_div;
          state_d     = CFG_PENDING;
          cfg_ready_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      CFG_PENDING: begin
        for (int i = 0; i < N_SUB; i++) begin
          if ((pend_sel_q == SEL_W'(i)) &&
              (wrap_next[i] || div_zero[i] || !run || sync)) begin
            load[i] = 1'b1;
          end
        end
        if (|load) begin
          state_d     = CFG_IDLE;
          cfg_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: state_d = CFG_IDLE;
    endcase
  end

  // Config FSM, pending slot and global tick registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= CFG_IDLE;
      pend_sel_q    <= '0;
      pend_div_q    <= '0;
      cfg_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      global_tick_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_sel_q    <= pend_sel_d;
      pend_div_q    <= pend_div_d;
      cfg_ready_q   <= cfg_ready_d;
      busy_q        <= busy_d;
      global_tick_q <= global_tick_d;
    end
  end

endmodule

// File: tb/tb_global_tick_gen.sv
// Self-checking bench for global_tick_gen with three channels so that an
// out-of-range channel select is representable.
module tb_global_tick_gen;
  import global_tick_pkg::*;

  localparam int N_SUB   = 3;
  localparam int DIV_W   = 8;
  localparam int DIV_RST = 1;
  localparam int SEL_W   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run = 1'b0;
  logic             sync = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [SEL_W-1:0] cfg_sel = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [N_SUB-1:0] tick;
  logic             global_tick;
  logic             busy;

  int compared = 0;
  int mismatched = 0;

  // Behavioural model: phase counter and divide value per channel, one slot.
  int m_cnt[N_SUB];
  int m_div[N_SUB];
  bit m_tick[N_SUB];
  bit m_global;
  bit m_pending;
  int m_psel;
  int m_pdiv;

  global_tick_gen #(
    .N_SUB  (N_SUB),
    .DIV_W  (DIV_W),
    .DIV_RST(DIV_RST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .sync       (sync),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_sel    (cfg_sel),
    .cfg_div    (cfg_div),
    .tick       (tick),
    .global_tick(global_tick),
    .busy       (busy)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N_SUB; i++) begin
      m_cnt[i]  = 0;
      m_div[i]  = DIV_RST;
      m_tick[i] = 1'b0;
    end
    m_global  = 1'b0;
    m_pending = 1'b0;
    m_psel    = 0;
    m_pdiv    = 0;
  endtask

  task automatic model_update();
    bit wr[N_SUB];
    bit app;
    int ps;
    ps = m_psel;
    for (int i = 0; i < N_SUB; i++)
      wr[i] = run && (m_div[i] != 0) && (m_cnt[i] % m_div[i] == m_div[i] - 1);
    app = m_pending && (wr[ps] || (m_div[ps] == 0) || !run || sync);
    for (int i = 0; i < N_SUB; i++) begin
      m_tick[i] = 1'b0;
      if (sync) m_cnt[i] = 0;
      else if (wr[i]) begin
        m_cnt[i]  = 0;
        m_tick[i] = 1'b1;
      end else if (run && m_div[i] != 0) m_cnt[i] = m_cnt[i] + 1;
    end
    if (app) begin
      m_div[ps] = m_pdiv;
      m_cnt[ps] = 0;
      m_pending = 1'b0;
    end else if (!m_pending && cfg_valid && int'(cfg_sel) < N_SUB) begin
      m_pending = 1'b1;
      m_psel    = int'(cfg_sel);
      m_pdiv    = int'(cfg_div);
    end
    m_global = 1'b0;
    for (int i = 0; i < N_SUB; i++) m_global |= m_tick[i];
  endtask

  function automatic logic [N_SUB+2:0] model_vec();
    logic [N_SUB-1:0] t;
    for (int i = 0; i < N_SUB; i++) t[i] = m_tick[i];
    return {t, m_global, !m_pending, m_pending};
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && m_pending; k++) step();
  endtask

  task automatic send_cfg(input int sel, input int dv);
    drain();
    cfg_sel   = SEL_W'(sel);
    cfg_div   = DIV_W'(dv);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({tick, global_tick, cfg_ready, busy} !== 6'b000010) begin
      mismatched++;
      $display("[TB] FAIL reset_values got=%b want=%b", {tick, global_tick, cfg_ready, busy}, 6'b000010);
    end
    rst_n = 1'b1;
    run   = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      compared++;
      if ({tick, global_tick} !== 4'b1111) begin
        mismatched++;
        $display("[TB] FAIL div1_every_cycle k=%0d got=%b want=1111", k, {tick, global_tick});
      end
    end
    #3 rst_n = 1'b0;
    #1;
    compared++;
    if ({tick, global_tick, cfg_ready, busy} !== 6'b000010) begin
      mismatched++;
      $display("[TB] FAIL async_reset got=%b want=%b", {tick, global_tick, cfg_ready, busy}, 6'b000010);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_periods();
    logic [3:0] want;
    send_cfg(2, 0);
    send_cfg(0, 4);
    send_cfg(1, 6);
    drain();
    sync = 1'b1;
    step();
    sync = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step();
      want = {1'b0, (k % 6 == 0), (k % 4 == 0), (k % 4 == 0) || (k % 6 == 0)};
      compared++;
      if ({tick, global_tick} !== want) begin
        mismatched++;
        $display("[TB] FAIL periods_4_6 k=%0d got=%b want=%b", k, {tick, global_tick}, want);
      end
      compared++;
      if ({tick, global_tick, cfg_ready, busy} !== model_vec()) begin
        mismatched++;
        $display("[TB] FAIL periods_model k=%0d got=%b want=%b", k, {tick, global_tick, cfg_ready, busy}, model_vec());
      end
    end
  endtask

  task automatic test_sync();
    repeat (5) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    compared++;
    if ({tick, global_tick} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL sync_no_tick got=%b want=0000", {tick, global_tick});
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      compared++;
      if (tick[1:0] !== {k == 6, k == 4 || k == 8}) begin
        mismatched++;
        $display("[TB] FAIL sync_realign k=%0d got=%b want=%b", k, tick[1:0], {k == 6, k == 4 || k == 8});
      end
    end
  endtask

  task automatic test_midperiod_update();
    send_cfg(0, 5);
    drain();
    sync = 1'b1;
    step();
    sync = 1'b0;
    repeat (2) step();
    cfg_sel   = SEL_W'(0);
    cfg_div   = DIV_W'(3);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    compared++;
    if ({cfg_ready, busy} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL midperiod_accept got=%b want=01", {cfg_ready, busy});
    end
    for (int j = 1; j <= 9; j++) begin
      step();
      compared++;
      if ({tick[0], busy} !== {j == 2 || j == 5 || j == 8, j < 2}) begin
        mismatched++;
        $display("[TB] FAIL midperiod j=%0d got=%b want=%b", j, {tick[0], busy}, {j == 2 || j == 5 || j == 8, j < 2});
      end
      compared++;
      if ({tick, global_tick, cfg_ready, busy} !== model_vec()) begin
        mismatched++;
        $display("[TB] FAIL midperiod_model j=%0d got=%b want=%b", j, {tick, global_tick, cfg_ready, busy}, model_vec());
      end
    end
  endtask

  task automatic test_run_pause();
    send_cfg(0, 4);
    drain();
    sync = 1'b1;
    step();
    sync = 1'b0;
    step();
    run = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cfg_sel   = SEL_W'(1);
      cfg_div   = DIV_W'(2);
      cfg_valid = (k == 3);
      step();
      cfg_valid = 1'b0;
      compared++;
      if ({tick, global_tick, busy} !== {4'b0000, k == 3}) begin
        mismatched++;
        $display("[TB] FAIL paused k=%0d got=%b want=%b", k, {tick, global_tick, busy}, {4'b0000, k == 3});
      end
    end
    run = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      compared++;
      if (tick[0] !== (j == 3)) begin
        mismatched++;
        $display("[TB] FAIL resume_phase j=%0d got=%b want=%b", j, tick[0], j == 3);
      end
      compared++;
      if ({tick, global_tick, cfg_ready, busy} !== model_vec()) begin
        mismatched++;
        $display("[TB] FAIL resume_model j=%0d got=%b want=%b", j, {tick, global_tick, cfg_ready, busy}, model_vec());
      end
    end
  endtask

  task automatic test_disable_and_oob();
    send_cfg(1, 0);
    drain();
    for (int k = 1; k <= 20; k++) begin
      step();
      compared++;
      if (tick[1] !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL disabled_ch1 k=%0d got=%b want=0", k, tick[1]);
      end
    end
    cfg_sel   = SEL_W'(3);
    cfg_div   = DIV_W'(7);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      compared++;
      if ({cfg_ready, busy} !== 2'b10) begin
        mismatched++;
        $display("[TB] FAIL oob_dropped k=%0d got=%b want=10", k, {cfg_ready, busy});
      end
      step();
    end
  endtask

  task automatic test_random();
    div_t rnd_div;
    for (int k = 0; k < 2000; k++) begin
      run       = ($urandom_range(0, 9) != 0);
      sync      = ($urandom_range(0, 39) == 0);
      cfg_valid = ($urandom_range(0, 4) == 0);
      cfg_sel   = SEL_W'($urandom_range(0, 3));
      rnd_div   = ($urandom_range(0, 3) != 0) ? div_t'($urandom_range(0, 6)) : div_t'($urandom_range(0, 40));
      cfg_div   = rnd_div;
      step();
      compared++;
      if ({tick, global_tick, cfg_ready, busy} !== model_vec()) begin
        mismatched++;
        $display("[TB] FAIL random k=%0d got=%b want=%b", k, {tick, global_tick, cfg_ready, busy}, model_vec());
      end
    end
    run = 1'b1; sync = 1'b0; cfg_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_periods();
    test_sync();
    test_midperiod_update();
    test_run_pause();
    test_disable_and_oob();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
